fifo_rd_serializer: RTL and testbench

- Downstream consumer of the 128-bit FIFO read port.
- Issues read strobes against the FIFO's empty/almost-empty flags and captures the read data.
- Serializes each 128-bit word into OUT_W-bit beats on a valid/ready stream toward the next stage.
- Keeps up to 2 words buffered or in flight, so beat throughput is 1 per cycle with no bubbles between words.

---
 rtl/fifo_rd_ser_pkg.sv | 17 +
 rtl/fifo_rd_ser_wbuf.sv | 52 +++++
 rtl/fifo_rd_serializer.sv | 132 +++++++++++++
 tb/tb_fifo_rd_serializer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_ser_pkg.sv
// Shared types and defaults for the FIFO read-side serializer.
// Optional word counter is enabled by defining FIFO_RD_SER_CNT_EN.
package fifo_rd_ser_pkg;

    localparam int unsigned DefDataW = 128;
    localparam int unsigned DefOutW  = 32;

    function automatic int unsigned ratio(input int unsigned data_w, input int unsigned out_w);
        return data_w / out_w;
    endfunction

    typedef enum logic {StIdle, StStream} state_e;

    // Beat index for the default geometry; the top derives its own width from its parameters.
    typedef logic [$clog2(DefDataW / DefOutW)-1:0] beat_idx_t;

endpackage

// File: rtl/fifo_rd_ser_wbuf.sv
// Two-entry word buffer between FIFO read capture and the beat serializer.
module fifo_rd_ser_wbuf
    import fifo_rd_ser_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              push_ok;
    logic              pop_ok;

    assign pop_ok  = pop_i && (count_q != 2'd0);
    assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);

    always_ff @(posedge clk) begin
        if (rstn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: ;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fifo_rd_serializer.sv
// Reads 128-bit words from a FIFO and streams them out LSB-first as OUT_W-bit beats.
// Define FIFO_RD_SER_CNT_EN to add the saturating o_word_cnt output.
module fifo_rd_serializer
    import fifo_rd_ser_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned OUT_W  = DefOutW,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rstn,
    output logic              o_rden,
    input  logic              i_empty,
    input  logic              i_alm_empty,
    input  logic [DATA_W-1:0] i_rddata,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [OUT_W-1:0]  o_data,
    output logic              o_last,
    output logic              o_busy
`ifdef FIFO_RD_SER_CNT_EN
    ,
    output logic [31:0]       o_word_cnt
`endif
);

    localparam int unsigned RATIO = ratio(DATA_W, OUT_W);
    localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    state_e                       state_q;
    logic [IDX_W-1:0]             idx_q;
    logic                         rden_q;
    logic                         rden_d;
    logic [RD_LAT-1:0]            pipe_q;
    logic [RD_LAT-1:0]            pipe_d;
    logic [1:0]                   inflight;
    logic [2:0]                   occ;
    logic [1:0]                   buf_cnt;
    logic [DATA_W-1:0]            head_word;
    logic [RATIO-1:0][OUT_W-1:0]  beats;
    logic                         capture;
    logic                         fire;
    logic                         last_beat;
    logic                         release_w;

    fifo_rd_ser_wbuf #(
        .DATA_W (DATA_W)
    ) u_wbuf (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (capture),
        .wdata_i (i_rddata),
        .pop_i   (release_w),
        .head_o  (head_word),
        .count_o (buf_cnt)
    );

    assign capture   = pipe_q[RD_LAT-1];
    assign fire      = o_valid && i_ready;
    assign last_beat = (idx_q == IDX_W'(RATIO - 1));
    assign release_w = fire && last_beat;
    assign pipe_d    = RD_LAT'({pipe_q, rden_q});

    always_comb begin
        inflight = 2'd0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            inflight = inflight + 2'(pipe_q[i]);
        end
    end

    // The strobe now on the wire already holds a credit, so it counts toward occupancy.
    always_comb begin
        occ    = 3'(buf_cnt) + 3'(inflight) + 3'(rden_q);
        rden_d = !i_empty
              && ((occ < 3'd2) || ((occ == 3'd2) && release_w))
              && !(i_alm_empty && rden_q);
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= StIdle;
            idx_q   <= '0;
            rden_q  <= 1'b0;
            pipe_q  <= '0;
        end else begin
            rden_q <= rden_d;
            pipe_q <= pipe_d;
            unique case (state_q)
                StIdle: begin
                    if (capture) begin
                        state_q <= StStream;
                    end
                end
                StStream: begin
                    if (fire) begin
                        if (last_beat) begin
                            idx_q <= '0;
                            if ((buf_cnt != 2'd2) && !capture) begin
                                state_q <= StIdle;
                            end
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign beats   = head_word;
    assign o_rden  = rden_q;
    assign o_valid = (state_q == StStream);
    assign o_data  = beats[idx_q];
    assign o_last  = o_valid && last_beat;
    assign o_busy  = (buf_cnt != 2'd0) || (|pipe_q) || rden_q || o_valid;

`ifdef FIFO_RD_SER_CNT_EN
    logic [31:0] word_cnt_q;

    always_ff @(posedge clk) begin
        if (rstn) begin
            word_cnt_q <= '0;
        end else if (release_w && (word_cnt_q != 32'hFFFF_FFFF)) begin
            word_cnt_q <= word_cnt_q + 32'd1;
        end
    end

    assign o_word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Scoreboard bench for fifo_rd_serializer against a behavioural FIFO with registered flags.
module tb_fifo_rd_serializer;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned OUT_W  = 32;
    localparam int unsigned RD_LAT = 1;

    logic              clk = 1'b0;
    logic              rstn;
    logic              o_rden;
    logic              i_empty = 1'b1;
    logic              i_alm_empty = 1'b0;
    logic [DATA_W-1:0] i_rddata = '0;
    logic              o_valid;
    logic              i_ready;
    logic [OUT_W-1:0]  o_data;
    logic              o_last;
    logic              o_busy;
`ifdef FIFO_RD_SER_CNT_EN
    logic [31:0]       o_word_cnt;
`endif

    fifo_rd_serializer #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .o_rden      (o_rden),
        .i_empty     (i_empty),
        .i_alm_empty (i_alm_empty),
        .i_rddata    (i_rddata),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_last      (o_last),
        .o_busy      (o_busy)
`ifdef FIFO_RD_SER_CNT_EN
        ,
        .o_word_cnt  (o_word_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int beats_seen = 0;
    int rden_cnt = 0;
    int run_len = 0;
    int max_run = 0;

    logic [DATA_W-1:0] fifo_q [$];
    logic [OUT_W:0]    exp_q [$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO model: flags and read data are registered, reset on the shared net.
    always @(posedge clk) begin
        if (rstn) begin
            fifo_q.delete();
            i_rddata    <= '0;
            i_empty     <= 1'b1;
            i_alm_empty <= 1'b0;
        end else begin
            if (o_rden) begin
                rden_cnt++;
                check("rden_while_empty", 128'(fifo_q.size() != 0), 128'(1));
                if (fifo_q.size() != 0) begin
                    i_rddata <= fifo_q.pop_front();
                end
            end
            i_empty     <= (fifo_q.size() == 0);
            i_alm_empty <= (fifo_q.size() == 1);
        end
    end

    // Beat monitor: a beat with valid & ready at the falling edge transfers on the next rise.
    always @(negedge clk) begin
        if (o_valid) run_len++;
        else run_len = 0;
        if (run_len > max_run) max_run = run_len;
        if (!rstn && o_valid && i_ready) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 128'(o_data), 128'(0));
            end else begin
                logic [OUT_W:0] e;
                e = exp_q.pop_front();
                check("beat_data", 128'(o_data), 128'(e[OUT_W-1:0]));
                check("beat_last", 128'(o_last), 128'(e[OUT_W]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        fifo_q.push_back(w);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({(k == 3), w[k*OUT_W +: OUT_W]});
        end
    endtask

    task automatic clear_stats();
        beats_seen = 0;
        rden_cnt   = 0;
        max_run    = 0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int i;
        i = 0;
        while (i < budget &&
               !(exp_q.size() == 0 && fifo_q.size() == 0 && !o_busy && !o_valid)) begin
            tick(1);
            i++;
        end
        check({tag, "_idle"}, 128'(i < budget), 128'(1));
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        int i;
        i = 0;
        while (i < budget && beats_seen < n) begin
            tick(1);
            i++;
        end
        check({tag, "_reached"}, 128'(beats_seen), 128'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] w;
        logic [DATA_W-1:0] wa;
        logic [DATA_W-1:0] wc;

        rstn    = 1'b1;
        i_ready = 1'b0;
        tick(3);
        check("rst_rden",  128'(o_rden),  128'(0));
        check("rst_valid", 128'(o_valid), 128'(0));
        check("rst_data",  128'(o_data),  128'(0));
        check("rst_last",  128'(o_last),  128'(0));
        check("rst_busy",  128'(o_busy),  128'(0));
        rstn = 1'b0;
        tick(2);

        // Single word
        clear_stats();
        push_word(128'h4444_4444_3333_3333_2222_2222_1111_1111);
        i_ready = 1'b1;
        wait_idle("single", 60);
        check("single_beats", 128'(beats_seen), 128'(4));
        check("single_run",   128'(max_run),    128'(4));
        check("single_rden",  128'(rden_cnt),   128'(1));

        // Streaming 8 preloaded words
        clear_stats();
        for (int i = 0; i < 8; i++) begin
            w = {$urandom(), $urandom(), $urandom(), $urandom()};
            push_word(w);
        end
        wait_idle("stream", 200);
        check("stream_beats", 128'(beats_seen), 128'(32));
        check("stream_run",   128'(max_run),    128'(32));
        check("stream_rden",  128'(rden_cnt),   128'(8));

        // Backpressure from beat 2 for 20 cycles
        clear_stats();
        wa = {$urandom(), $urandom(), $urandom(), $urandom()};
        push_word(wa);
        for (int i = 0; i < 3; i++) begin
            w = {$urandom(), $urandom(), $urandom(), $urandom()};
            push_word(w);
        end
        wait_beats("bp", 2, 60);
        i_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            check("bp_hold_data",  128'(o_data),  128'(wa[95:64]));
            check("bp_hold_valid", 128'(o_valid), 128'(1));
            check("bp_hold_last",  128'(o_last),  128'(0));
            if (c >= 4) check("bp_rden_low", 128'(o_rden), 128'(0));
            tick(1);
        end
        check("bp_fifo_left", 128'(fifo_q.size()), 128'(2));
        i_ready = 1'b1;
        wait_idle("bp", 120);
        check("bp_beats", 128'(beats_seen), 128'(16));
        check("bp_rden",  128'(rden_cnt),   128'(4));

        // Almost-empty: two words only
        clear_stats();
        for (int i = 0; i < 2; i++) begin
            w = {$urandom(), $urandom(), $urandom(), $urandom()};
            push_word(w);
        end
        wait_idle("alm", 80);
        check("alm_rden",  128'(rden_cnt),   128'(2));
        check("alm_beats", 128'(beats_seen), 128'(8));

        // Reset mid-word with a second word buffered
        clear_stats();
        wa = {$urandom(), $urandom(), $urandom(), $urandom()};
        push_word(wa);
        w = {$urandom(), $urandom(), $urandom(), $urandom()};
        push_word(w);
        wait_beats("mid", 2, 60);
        rstn = 1'b1;
        exp_q.delete();
        tick(1);
        check("mid_valid", 128'(o_valid), 128'(0));
        check("mid_busy",  128'(o_busy),  128'(0));
        rstn = 1'b0;
        tick(1);
        clear_stats();
        wc = {$urandom(), $urandom(), $urandom(), $urandom()};
        push_word(wc);
        for (int i = 0; i < 40 && !o_valid; i++) tick(1);
        check("mid_first_beat", 128'(o_data), 128'(wc[31:0]));
        wait_idle("mid", 60);
        check("mid_beats", 128'(beats_seen), 128'(4));
        check("mid_rden",  128'(rden_cnt),   128'(1));

`ifdef FIFO_RD_SER_CNT_EN
        rstn = 1'b1;
        tick(1);
        check("cnt_rst0", 128'(o_word_cnt), 128'(0));
        rstn = 1'b0;
        tick(1);
        clear_stats();
        for (int i = 0; i < 5; i++) begin
            w = {$urandom(), $urandom(), $urandom(), $urandom()};
            push_word(w);
        end
        wait_idle("cnt", 150);
        check("cnt_five", 128'(o_word_cnt), 128'(5));
        rstn = 1'b1;
        tick(1);
        check("cnt_rst1", 128'(o_word_cnt), 128'(0));
        rstn = 1'b0;
        tick(1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
